mdu_hilo_ctrl: RTL and testbench
================================

# mdu_hilo_ctrl

Multiply/divide sequencer and HI/LO register owner for the EX stage. It runs MULT/MULTU as a one-extra-cycle multiply and DIV/DIVU as a 32-iteration restoring divider, and executes MTHI/MTLO writes. While an operation is in flight it stalls the pipeline, and it aborts cleanly on an exception flush. It sits beside the ALU, driven by the same decoded EX-stage instruction.

## Interface
Parameters:
- none; data width is fixed at 32.

Ports:
- clk  input  1  clock; every register updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  EX holds a valid MDU instruction.
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- a  input  32  rs value: dividend, multiplicand, or MTHI/MTLO data.
- b  input  32  rt value: divisor or multiplier.
- cancel  input  1  exception flush; aborts any operation.
- stall  output  1  combinational; holds IF through EX.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- Reset while resetn=0: state=IDLE, hi=0, lo=0, stall=0, iteration counter=0, internal operand registers=0.
- The FSM has four states: IDLE, MUL, DIV, DONE.
- IDLE behaviour with start=1 and cancel=0:
  - MULT/MULTU: latch a, b and signedness, stall=1, go to MUL.
  - DIV/DIVU with b!=0: latch the operand magnitudes and the sign flags, clear the partial remainder, set counter=0, stall=1, go to DIV.
  - DIV/DIVU with b=0: stall=0, hi/lo unchanged, stay in IDLE.
  - MTHI: hi<=a. MTLO: lo<=a. stall=0 for both, stay in IDLE.
  - op 6/7: nothing happens.
- MUL state:
  - Compute the 64-bit product, signed or unsigned; {hi,lo}<=product at the end of the cycle.
  - stall=0; start is ignored, because it is the same instruction about to leave EX. Go to IDLE.
- DIV state, one restoring step per cycle:
  - Shift {rem,quo} left by one; trial = rem - divisor (33-bit compare).
  - If trial>=0: rem=trial and quo[0]=1.
  - counter increments each step. At counter=31 the last step completes and the FSM goes to DONE.
  - stall=1 throughout.
- DONE state:
  - Apply signs: the quotient is negated if the operand signs differ (signed ops only); the remainder takes the dividend's sign.
  - lo<=quotient and hi<=remainder at the end of the cycle.
  - stall=0, start is ignored, then go to IDLE.
- Signed magnitude arithmetic uses 32-bit unsigned magnitudes. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (the wrap is intended).
- cancel=1 in any state:
  - stall=0 combinationally that cycle and start is ignored.
  - No hi/lo write occurs, including MTHI/MTLO in the same cycle and the final write from MUL/DONE.
  - The FSM returns to IDLE at the next edge.
- Reset asserted mid-operation forces the reset values immediately (asynchronous reset).

## Timing
- MULT/MULTU: stall is high for exactly 1 cycle (the start cycle). The new hi/lo is visible one cycle after the MUL cycle.
- DIV/DIVU: stall is high for 33 cycles (start cycle plus 32 DIV cycles) and low in DONE. The new hi/lo is visible in the cycle after DONE.
- MTHI/MTLO: zero stall; the value is visible the next cycle.
- An instruction following in EX (for example MFHI) immediately after MUL/DONE reads the updated hi/lo with no forwarding needed.
- A start that arrives in MUL or DONE is never relaunched. A new operation can launch only from IDLE, in the cycle right after MUL/DONE.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5: stall=1 for 1 cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands gives hi=0x00000004, lo=0xFFFFFFF1.
- DIVU a=100, b=7: stall high for exactly 33 consecutive cycles, then lo=14, hi=2. Holding start high through DONE must not relaunch the operation.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. For DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- DIV a=5, b=0 with hi=0x11, lo=0x22: stall never rises and hi/lo stay 0x11/0x22. Then MTHI a=0xABCD gives hi=0xABCD the next cycle with no stall.
- DIVU 100/7 with cancel pulsed on the 10th DIV cycle: stall drops that cycle, hi/lo are unchanged, and the FSM is in IDLE. A following DIVU 9/3 then takes the full 33 cycles and gives lo=3, hi=0.
- Assert resetn=0 mid-DIV: hi=lo=0 and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mdu_hilo_ctrl_if.sv
// EX-stage <-> MDU bundle: decoded instruction and flush in, stall and HI/LO out.
interface mdu_hilo_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, cancel, input stall, hi, lo);
    modport slave  (input start, op, a, b, cancel, output stall, hi, lo);
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// Multiply/divide sequencer owning HI/LO: single-cycle multiply, 32-step
// restoring divide, MTHI/MTLO, with pipeline stall and flush abort.
module mdu_hilo_ctrl (
    input  logic             clk,
    input  logic             resetn,
    mdu_hilo_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic        stall;
    logic [31:0] hi_q, lo_q;
    logic [31:0] opa, opb;
    logic [31:0] rem, quo;
    logic [4:0]  cnt;
    logic        msgn, neg_q, neg_r;

    logic        is_mul, is_div, sgn_op, b_nz;
    logic [31:0] mag_a, mag_b;
    logic [63:0] ext_a, ext_b, prod;
    logic [32:0] rs;
    logic        ge;
    logic [31:0] rem_nxt, q_fin, r_fin;

    assign is_mul = (bus.op == 3'd0) || (bus.op == 3'd1);
    assign is_div = (bus.op == 3'd2) || (bus.op == 3'd3);
    assign sgn_op = ~bus.op[0];
    assign b_nz   = (bus.b != 32'd0);
    assign mag_a  = (sgn_op && bus.a[31]) ? -bus.a : bus.a;
    assign mag_b  = (sgn_op && bus.b[31]) ? -bus.b : bus.b;

    assign ext_a  = {{32{msgn & opa[31]}}, opa};
    assign ext_b  = {{32{msgn & opb[31]}}, opb};
    assign prod   = ext_a * ext_b;

    // Result is below the divisor whenever the compare passes, so 32 bits suffice.
    assign rs      = {rem, quo[31]};
    assign ge      = rs >= {1'b0, opb};
    assign rem_nxt = ge ? (rs[31:0] - opb) : rs[31:0];

    assign q_fin = neg_q ? -quo : quo;
    assign r_fin = neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (is_mul) begin
                        stall     = 1'b1;
                        state_nxt = MUL;
                    end else if (is_div && b_nz) begin
                        stall     = 1'b1;
                        state_nxt = DIV;
                    end
                end
            end
            MUL:  state_nxt = IDLE;
            DIV: begin
                stall = 1'b1;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Flush overrides everything, including a launch from IDLE.
        if (bus.cancel) begin
            stall     = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q  <= '0;
            lo_q  <= '0;
            opa   <= '0;
            opb   <= '0;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            msgn  <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        3'd0, 3'd1: begin
                            opa  <= bus.a;
                            opb  <= bus.b;
                            msgn <= sgn_op;
                        end
                        3'd2, 3'd3: if (b_nz) begin
                            quo   <= mag_a;
                            opb   <= mag_b;
                            rem   <= '0;
                            cnt   <= '0;
                            neg_q <= sgn_op & (bus.a[31] ^ bus.b[31]);
                            neg_r <= sgn_op & bus.a[31];
                        end
                        3'd4: hi_q <= bus.a;
                        3'd5: lo_q <= bus.a;
                        default: ;
                    endcase
                end
                MUL: if (!bus.cancel) {hi_q, lo_q} <= prod;
                DIV: begin
                    rem <= rem_nxt;
                    quo <= {quo[30:0], ge};
                    cnt <= cnt + 5'd1;
                end
                DONE: if (!bus.cancel) begin
                    lo_q <= q_fin;
                    hi_q <= r_fin;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall = stall;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl: expected HI/LO queued at launch, checked on completion.
module tb_mdu_hilo_ctrl;
    logic clk;
    logic resetn;
    mdu_hilo_ctrl_if bus();

    mdu_hilo_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hilo(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " hi"}, bus.hi, e.hi);
            chk({tag, " lo"}, bus.lo, e.lo);
        end
    endtask

    // Called just after a rising edge; holds start until stall drops,
    // then checks stall length, the written HI/LO, and that no relaunch happened.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int exp_st, input string tag);
        int  n = 0;
        bit  done = 0;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.stall) begin
                n++;
                @(posedge clk); #1;
            end else begin
                done = 1;
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, " stall cycles"}, 32'(n), 32'(exp_st));
        @(negedge clk);
        chk_hilo(tag);
        chk({tag, " idle after"}, {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        resetn     = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        #12;
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        chk("reset stall", {31'd0, bus.stall}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1});
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 1, "mult");
        sb.push_back('{hi: 32'h00000004, lo: 32'hFFFFFFF1});
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1, "multu");
        sb.push_back('{hi: 32'd2, lo: 32'd14});
        run_op(3'd3, 32'd100, 32'd7, 33, "divu 100/7");
        sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 33, "div -7/2");
        sb.push_back('{hi: 32'd0, lo: 32'h80000000});
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 33, "div min/-1");
        sb.push_back('{hi: 32'h11, lo: 32'h80000000});
        run_op(3'd4, 32'h11, 32'd0, 0, "mthi");
        sb.push_back('{hi: 32'h11, lo: 32'h22});
        run_op(3'd5, 32'h22, 32'd0, 0, "mtlo");
        sb.push_back('{hi: 32'h11, lo: 32'h22});
        run_op(3'd2, 32'd5, 32'd0, 0, "div by zero");
        sb.push_back('{hi: 32'hABCD, lo: 32'h22});
        run_op(3'd4, 32'hABCD, 32'd0, 0, "mthi abcd");

        // MTLO flushed in its own cycle must not write
        sb.push_back('{hi: 32'hABCD, lo: 32'h22});
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hDEAD; bus.cancel = 1'b1;
        @(negedge clk);
        chk("mtlo cancel stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        @(negedge clk);
        chk_hilo("mtlo cancel");
        @(posedge clk); #1;

        // DIVU flushed on its 10th DIV cycle
        sb.push_back('{hi: 32'hABCD, lo: 32'h22});
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        chk("divcancel launch stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        @(negedge clk);
        chk("divcancel pre stall", {31'd0, bus.stall}, 32'd1);
        #1;
        bus.cancel = 1'b1;
        #1;
        chk("divcancel stall drop", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        chk("divcancel idle", {31'd0, bus.stall}, 32'd0);
        chk_hilo("divcancel");
        @(posedge clk); #1;

        sb.push_back('{hi: 32'd0, lo: 32'd3});
        run_op(3'd3, 32'd9, 32'd3, 33, "divu 9/3");

        // MULT flushed in the MUL cycle keeps old HI/LO
        sb.push_back('{hi: 32'd0, lo: 32'd3});
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd6;
        @(negedge clk);
        chk("mulcancel launch stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        @(negedge clk);
        chk_hilo("mulcancel");
        @(posedge clk); #1;

        sb.push_back('{hi: 32'h1234, lo: 32'd3});
        run_op(3'd4, 32'h1234, 32'd0, 0, "mthi 1234");

        // Asynchronous reset in the middle of a divide
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre-reset stall", {31'd0, bus.stall}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("async reset hi", bus.hi, 32'd0);
        chk("async reset lo", bus.lo, 32'd0);
        chk("async reset stall", {31'd0, bus.stall}, 32'd0);
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-reset idle", {31'd0, bus.stall}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
